// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Multi-cycle sequencer for the 8-bit ALU opcode set. Commands arrive on a
//   valid/ready handshake, results leave on another. Add/sub/nop/unknown and
//   divide-by-zero finish in a single cycle. Mul is an iterative shift-add.
//   Div/mod use iterative restoring division, one bit per cycle.
//
//   Optional feature macro: ALU_SEQ_STATS_EN
//     defined   -> op_count/err_count ports present, saturating counters
//     undefined -> counters and their ports are absent
//
//   Ports
//     clk, reset_n           clock, asynchronous active-low reset
//     in_valid/in_ready      command handshake (in_ready = state is IDLE)
//     in_op[7:0]             0 nop, 1 add, 2 sub, 3 mul, 4 div, 5 mod
//     in_a, in_b [WIDTH]     unsigned operands, sampled only on accept
//     out_valid/out_ready    result handshake
//     out_result [2*WIDTH]   result, held stable while out_valid is high
//     out_err                div/mod by zero or unknown opcode
//     busy                   state != IDLE
//     op_count, err_count    handshake / errored-handshake counters (stats)
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic                 out_err,
    output logic                 busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [CNT_W-1:0]     op_count,
    output logic [CNT_W-1:0]     err_count
`endif
);

    localparam int unsigned IW = $clog2(WIDTH + 1);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 2) begin : g_width_check
        $error("alu_op_sequencer: WIDTH must be at least 2");
    end
    if (CNT_W < 1) begin : g_cnt_check
        $error("alu_op_sequencer: CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        K_MUL,
        K_DIV,
        K_MOD
    } kind_t;

    state_t               r_state;
    state_t               w_state_next;
    kind_t                r_kind;
    logic [IW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_acc;     // mul accumulator
    logic [2*WIDTH-1:0]   r_x;       // mul multiplicand, shifted left each step
    logic [WIDTH-1:0]     r_y;       // mul multiplier / div dividend->quotient
    logic [WIDTH-1:0]     r_rem;     // div partial remainder
    logic [WIDTH-1:0]     r_b;       // divisor
    logic [2*WIDTH-1:0]   r_result;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_hs;
    logic                 w_long;
    logic                 w_last;
    logic [2*WIDTH-1:0]   w_quick_res;
    logic                 w_quick_err;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [WIDTH:0]       w_trial;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_quo_next;

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    assign out_result = r_result;
    assign out_err    = r_err;

    assign w_accept = in_valid && in_ready;
    assign w_hs     = out_valid && out_ready;
    // Only mul and div/mod with a non-zero divisor need iterations.
    assign w_long   = (in_op == 8'd3) ||
                      (((in_op == 8'd4) || (in_op == 8'd5)) && (in_b != '0));
    assign w_last   = (r_state == S_CALC) && (r_cnt == IW'(1));

    // Single-cycle results, computed straight from the inputs at accept.
    always_comb begin
        w_quick_res = '0;
        w_quick_err = 1'b0;
        case (in_op)
            8'd0: w_quick_res = '0;
            8'd1: w_quick_res = {{WIDTH{1'b0}}, in_a} + {{WIDTH{1'b0}}, in_b};
            8'd2: w_quick_res = {{WIDTH{1'b0}}, in_a} - {{WIDTH{1'b0}}, in_b};
            8'd3: w_quick_res = '0;
            8'd4, 8'd5: begin
                // Reached only with in_b == 0 (other cases go to CALC).
                w_quick_res = '1;
                w_quick_err = 1'b1;
            end
            default: begin
                w_quick_res = '0;
                w_quick_err = 1'b1;
            end
        endcase
    end

    // One iteration step of each algorithm.
    always_comb begin
        w_acc_next = r_acc + (r_y[0] ? r_x : '0);
        w_trial    = {r_rem, r_y[WIDTH-1]};
        w_ge       = (w_trial >= {1'b0, r_b});
        // When w_ge holds the difference is below r_b, so WIDTH bits suffice.
        w_rem_next = w_ge ? (w_trial[WIDTH-1:0] - r_b) : w_trial[WIDTH-1:0];
        w_quo_next = {r_y[WIDTH-2:0], w_ge};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_long ? S_CALC : S_DONE;
            S_CALC: if (w_last)   w_state_next = S_DONE;
            S_DONE: if (w_hs)     w_state_next = S_IDLE;
            default:              w_state_next = S_IDLE;
        endcase
    end

    // Datapath.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_kind   <= K_MUL;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_rem    <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= IW'(WIDTH);
            r_acc <= '0;
            r_x   <= {{WIDTH{1'b0}}, in_a};
            r_y   <= (in_op == 8'd3) ? in_b : in_a;
            r_rem <= '0;
            r_b   <= in_b;
            case (in_op)
                8'd3:    r_kind <= K_MUL;
                8'd4:    r_kind <= K_DIV;
                default: r_kind <= K_MOD;
            endcase
            if (!w_long) begin
                r_result <= w_quick_res;
                r_err    <= w_quick_err;
            end
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt - IW'(1);
            if (r_kind == K_MUL) begin
                r_acc <= w_acc_next;
                r_x   <= r_x << 1;
                r_y   <= r_y >> 1;
            end else begin
                r_rem <= w_rem_next;
                r_y   <= w_quo_next;
            end
            // Final step: capture the post-iteration value directly.
            if (w_last) begin
                r_err <= 1'b0;
                case (r_kind)
                    K_MUL:   r_result <= w_acc_next;
                    K_DIV:   r_result <= {{WIDTH{1'b0}}, w_quo_next};
                    default: r_result <= {{WIDTH{1'b0}}, w_rem_next};
                endcase
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [CNT_W-1:0] r_op_count;
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op_count  <= '0;
            r_err_count <= '0;
        end else if (w_hs) begin
            if (r_op_count != '1) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
            if (r_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

    assign op_count  = r_op_count;
    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//   Scoreboard bench: each command pushes its modelled result and latency;
//   the entry is popped and compared when out_valid appears.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int unsigned W = 8;
    localparam int unsigned C = 16;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           in_valid;
    logic           in_ready;
    logic [7:0]     in_op;
    logic [W-1:0]   in_a;
    logic [W-1:0]   in_b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_result;
    logic           out_err;
    logic           busy;
`ifdef ALU_SEQ_STATS_EN
    logic [C-1:0]   op_count;
    logic [C-1:0]   err_count;
`endif

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .busy       (busy)
`ifdef ALU_SEQ_STATS_EN
        ,
        .op_count   (op_count),
        .err_count  (err_count)
`endif
    );

    typedef struct {
        logic [2*W-1:0] res;
        logic           err;
        int             lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_ops = 0;
    int   exp_errs = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] ea, eb;
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        e.res = '0;
        e.err = 1'b0;
        e.lat = 1;
        case (op)
            8'd0: e.res = '0;
            8'd1: e.res = ea + eb;
            8'd2: e.res = ea - eb;
            8'd3: begin e.res = ea * eb; e.lat = W + 1; end
            8'd4, 8'd5: begin
                if (b == '0) begin
                    e.res = '1;
                    e.err = 1'b1;
                end else begin
                    e.res = (op == 8'd4) ? ea / eb : ea % eb;
                    e.lat = W + 1;
                end
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    // Drive one command, hold out_ready low for 'hold' cycles once the
    // result shows, then complete the output handshake.
    task automatic run_op(input string tag, input logic [7:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold);
        int   lat;
        int   waited;
        exp_t e;
        @(negedge clk);
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check_eq({tag, ".ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        out_ready = (hold == 0);
        sb.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble inputs: they must be ignored after accept.
        in_op = 8'($urandom);
        in_a  = W'($urandom);
        in_b  = W'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        e = sb.pop_front();
        if (!out_valid) begin
            check_eq({tag, ".valid_timeout"}, 32'd0, 32'd1);
            return;
        end
        check_eq({tag, ".lat"}, lat, e.lat);
        check_eq({tag, ".res"}, out_result, e.res);
        check_eq({tag, ".err"}, out_err, e.err);
        check_eq({tag, ".busy"}, busy, 1'b1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, ".hold_res"}, out_result, e.res);
            check_eq({tag, ".hold_vld"}, out_valid, 1'b1);
            check_eq({tag, ".hold_rdy"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        check_eq({tag, ".hs_rdy"}, in_ready, 1'b0);
        @(posedge clk);
        #1;
        exp_ops++;
        if (e.err) exp_errs++;
        check_eq({tag, ".post_vld"}, out_valid, 1'b0);
        check_eq({tag, ".post_rdy"}, in_ready, 1'b1);
    endtask

    initial begin
        int seen;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst.vld",  out_valid,  1'b0);
        check_eq("rst.rdy",  in_ready,   1'b1);
        check_eq("rst.busy", busy,       1'b0);
        check_eq("rst.res",  out_result, 16'd0);
        check_eq("rst.err",  out_err,    1'b0);
        reset_n = 1'b1;

        run_op("add",  8'd1, 8'd200, 8'd100, 0);
        run_op("sub",  8'd2, 8'd3,   8'd5,   0);
        run_op("mul",  8'd3, 8'd255, 8'd255, 0);
        run_op("div",  8'd4, 8'd200, 8'd7,   0);
        run_op("mod",  8'd5, 8'd200, 8'd7,   0);
        run_op("div0", 8'd4, 8'd9,   8'd0,   0);
        run_op("op9",  8'd9, 8'd17,  8'd33,  0);
`ifdef ALU_SEQ_STATS_EN
        check_eq("stats.ops", op_count,  16'd7);
        check_eq("stats.err", err_count, 16'd2);
`endif

        run_op("bp_mul", 8'd3, 8'd12, 8'd12, 5);

        // Reset during CALC of a div: the op must vanish.
        @(negedge clk);
        in_valid = 1'b1; in_op = 8'd4; in_a = 8'd200; in_b = 8'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("mid.busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("mid.vld",  out_valid,  1'b0);
        check_eq("mid.busy0", busy,      1'b0);
        check_eq("mid.res",  out_result, 16'd0);
        check_eq("mid.err",  out_err,    1'b0);
`ifdef ALU_SEQ_STATS_EN
        check_eq("mid.ops",  op_count,  16'd0);
        check_eq("mid.errs", err_count, 16'd0);
`endif
        exp_ops  = 0;
        exp_errs = 0;
        @(negedge clk);
        reset_n = 1'b1;
        check_eq("mid.rdy", in_ready, 1'b1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check_eq("mid.ghost", seen, 0);

        for (int i = 0; i < 24; i++) begin
            run_op("rnd", 8'($urandom_range(0, 7)), W'($urandom),
                   (i % 5 == 0) ? W'(0) : W'($urandom), $urandom_range(0, 2));
        end
        run_op("mod0", 8'd5, 8'd77, 8'd0, 1);
        run_op("nop",  8'd0, 8'd55, 8'd66, 0);

        check_eq("sb.empty", sb.size(), 0);
`ifdef ALU_SEQ_STATS_EN
        check_eq("end.ops",  op_count,  exp_ops);
        check_eq("end.errs", err_count, exp_errs);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
